// File: rtl/fetch_control_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_control_pkg;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  localparam logic [5:0]  HALT_OPCODE        = 6'b111111;
  localparam logic [31:0] NOP_INSTR          = 32'h0;
  localparam int          DEFAULT_IMEM_DEPTH = 128;
  localparam int          PC_IDX_W           = $clog2(DEFAULT_IMEM_DEPTH);

endpackage

// File: rtl/fetch_control_if_id_reg.sv
// IF/ID pipeline register: load a fetched word, hold on stall, or flush the valid bit.
module if_id_reg
  import fetch_control_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            flush,
  input  logic [31:0]     instr_in,
  input  logic [PC_W-1:0] pc_in,
  output logic [31:0]     if_instr,
  output logic [PC_W-1:0] if_pc,
  output logic            if_valid
);

  logic [31:0]     instr_reg;
  logic [PC_W-1:0] pc_reg;
  logic            valid_reg;

  // Flush only drops the valid bit; stale payload is harmless once invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_reg <= NOP_INSTR;
      pc_reg    <= '0;
      valid_reg <= 1'b0;
    end else if (flush) begin
      valid_reg <= 1'b0;
    end else if (load) begin
      instr_reg <= instr_in;
      pc_reg    <= pc_in;
      valid_reg <= 1'b1;
    end
  end

  assign if_instr = instr_reg;
  assign if_pc    = pc_reg;
  assign if_valid = valid_reg;

endmodule

// File: rtl/fetch_control.sv
// Fetch stage: owns pc, handles stall/redirect/halt, feeds the IF/ID register.
// Define FETCH_COUNT_EN to build the fetched-instruction counter.
module fetch_control
  import fetch_control_pkg::*;
#(
  parameter int          PC_W       = 32,
  parameter int          IMEM_DEPTH = 128,
  parameter int unsigned RESET_PC   = 0
) (
  input  logic            clk,
  input  logic            rst,
  output logic [PC_W-1:0] pc,
  input  logic [31:0]     instr,
  input  logic            isdone,
  input  logic            stall,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  output logic [31:0]     if_instr,
  output logic [PC_W-1:0] if_pc,
  output logic            if_valid,
  output logic            halted,
  output logic [31:0]     fetch_count
);

  // Depth is a power of two, so masking keeps pc inside the memory.
  localparam logic [PC_W-1:0] PC_MASK      = PC_W'(IMEM_DEPTH - 1);
  localparam logic [PC_W-1:0] RESET_PC_IDX = PC_W'(RESET_PC) & PC_MASK;

  fetch_state_t    state_reg, state_next;
  logic [PC_W-1:0] pc_reg, pc_next;
  logic            load, flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= RUN;
      pc_reg    <= RESET_PC_IDX;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    case (state_reg)
      RUN: begin
        if (redirect) begin
          pc_next = redirect_pc & PC_MASK;
        end else if (stall) begin
          pc_next = pc_reg;
        end else if (isdone) begin
          state_next = HALT;
        end else begin
          pc_next = (pc_reg == PC_MASK) ? '0 : pc_reg + PC_W'(1);
        end
      end
      default: begin
        state_next = HALT;
      end
    endcase
  end

  always_comb begin
    load   = 1'b0;
    flush  = 1'b0;
    halted = (state_reg == HALT);
    case (state_reg)
      RUN: begin
        if (redirect) begin
          flush = 1'b1;
        end else if (stall) begin
          flush = 1'b0;
        end else if (isdone) begin
          flush = 1'b1;
        end else begin
          load = 1'b1;
        end
      end
      default: begin
        flush = 1'b1;
      end
    endcase
  end

  assign pc = pc_reg;

  if_id_reg #(
    .PC_W(PC_W)
  ) u_if_id (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .flush    (flush),
    .instr_in (instr),
    .pc_in    (pc_reg),
    .if_instr (if_instr),
    .if_pc    (if_pc),
    .if_valid (if_valid)
  );

`ifdef FETCH_COUNT_EN
  logic [31:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= count_reg + 32'd1;
    end
  end

  assign fetch_count = count_reg;
`else
  assign fetch_count = '0;
`endif

endmodule
